// File: rtl/user_wb_pkg.sv
// Shared types and constants for the user-project Wishbone interconnect.
// Holds the bus widths, the default sub-block base addresses and the FSM state type.
package user_wb_pkg;

  localparam int WB_DW = 32;
  localparam int WB_AW = 32;

  localparam logic [11:0] FIR_BASE   = 12'h320;
  localparam logic [11:0] MM_BASE    = 12'h340;
  localparam logic [11:0] SDRAM_BASE = 12'h380;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } wb_state_e;

  // Error counter sticks at all-ones instead of wrapping back to zero.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/user_wb_addr_decode.sv
// Combinational decoder: compares the upper address tag against each slave base.
// When several bases match, the lowest slave index wins.
module user_wb_addr_decode
  import user_wb_pkg::*;
#(
  parameter int                     N_SLV      = 3,
  parameter int                     DEC_W      = 12,
  parameter int                     IDX_W      = 2,
  parameter logic [N_SLV*DEC_W-1:0] BASE_ADDRS = {SDRAM_BASE, MM_BASE, FIR_BASE}
) (
  input  logic [DEC_W-1:0] tag,
  output logic             hit,
  output logic [IDX_W-1:0] idx
);

  always_comb begin
    // NOTE: defaults first so no path leaves hit/idx unassigned (no latch).
    hit = 1'b0;
    idx = '0;
    // Scan downwards so the last match written is the lowest index.
    for (int k = N_SLV - 1; k >= 0; k--) begin
      if (tag == BASE_ADDRS[k*DEC_W +: DEC_W]) begin
        hit = 1'b1;
        idx = IDX_W'(k);
      end
    end
  end

endmodule

// File: rtl/user_wb_interconnect.sv
// Wishbone slave-side interconnect: routes one master transaction to one of N_SLV
// sub-blocks and adds unmapped-address errors, a timeout watchdog and abort handling.
module user_wb_interconnect
  import user_wb_pkg::*;
#(
  parameter int                     N_SLV      = 3,
  parameter int                     DEC_W      = 12,
  parameter logic [N_SLV*DEC_W-1:0] BASE_ADDRS = {SDRAM_BASE, MM_BASE, FIR_BASE},
  parameter int                     TIMEOUT    = 255,
  parameter logic [WB_DW-1:0]       ERR_DATA   = 32'hDEAD_BEEF
) (
  input  logic                   wb_clk_i,
  input  logic                   wb_rst_i,
  input  logic                   wbs_cyc_i,
  input  logic                   wbs_stb_i,
  input  logic                   wbs_we_i,
  input  logic [3:0]             wbs_sel_i,
  input  logic [WB_AW-1:0]       wbs_adr_i,
  input  logic [WB_DW-1:0]       wbs_dat_i,
  output logic                   wbs_ack_o,
  output logic [WB_DW-1:0]       wbs_dat_o,
  output logic [N_SLV-1:0]       s_cyc_o,
  output logic [N_SLV-1:0]       s_stb_o,
  output logic                   s_we_o,
  output logic [3:0]             s_sel_o,
  output logic [WB_AW-1:0]       s_adr_o,
  output logic [WB_DW-1:0]       s_dat_o,
  input  logic [N_SLV-1:0]       s_ack_i,
  input  logic [N_SLV*WB_DW-1:0] s_dat_i,
  output logic                   err_o,
  output logic [15:0]            err_count_o
);

  localparam int IDX_W = (N_SLV > 1) ? $clog2(N_SLV) : 1;
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);

  wb_state_e        state;
  logic [IDX_W-1:0] sel_idx;
  logic [CNT_W-1:0] tmo_cnt;
  logic [N_SLV-1:0] slv_req;
  logic             dec_hit;
  logic [IDX_W-1:0] dec_idx;

  user_wb_addr_decode #(
    .N_SLV      (N_SLV),
    .DEC_W      (DEC_W),
    .IDX_W      (IDX_W),
    .BASE_ADDRS (BASE_ADDRS)
  ) u_dec (
    .tag (wbs_adr_i[WB_AW-1 -: DEC_W]),
    .hit (dec_hit),
    .idx (dec_idx)
  );

  // Cycle and strobe are always raised and dropped together.
  assign s_cyc_o = slv_req;
  assign s_stb_o = slv_req;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      // NOTE: non-blocking assignments for every piece of sequential state.
      state       <= IDLE;
      sel_idx     <= '0;
      tmo_cnt     <= '0;
      slv_req     <= '0;
      s_we_o      <= 1'b0;
      s_sel_o     <= '0;
      s_adr_o     <= '0;
      s_dat_o     <= '0;
      wbs_ack_o   <= 1'b0;
      wbs_dat_o   <= '0;
      err_o       <= 1'b0;
      err_count_o <= '0;
    end else begin
      err_o <= 1'b0;
      case (state)
        IDLE: begin
          if (wbs_cyc_i && wbs_stb_i) begin
            if (dec_hit) begin
              sel_idx          <= dec_idx;
              s_we_o           <= wbs_we_i;
              s_sel_o          <= wbs_sel_i;
              s_adr_o          <= wbs_adr_i;
              s_dat_o          <= wbs_dat_i;
              slv_req          <= '0;
              slv_req[dec_idx] <= 1'b1;
              tmo_cnt          <= '0;
              state            <= BUSY;
            end else begin
              wbs_dat_o   <= ERR_DATA;
              wbs_ack_o   <= 1'b1;
              err_o       <= 1'b1;
              err_count_o <= sat_inc16(err_count_o);
              state       <= RESP;
            end
          end
        end
        BUSY: begin
          if (!wbs_cyc_i) begin
            slv_req <= '0;
            state   <= IDLE;
          end else if (s_ack_i[sel_idx]) begin
            slv_req   <= '0;
            wbs_dat_o <= s_we_o ? '0 : s_dat_i[int'(sel_idx)*WB_DW +: WB_DW];
            wbs_ack_o <= 1'b1;
            state     <= RESP;
          end else if (tmo_cnt == TMO_LAST) begin
            slv_req     <= '0;
            wbs_dat_o   <= ERR_DATA;
            wbs_ack_o   <= 1'b1;
            err_o       <= 1'b1;
            err_count_o <= sat_inc16(err_count_o);
            state       <= RESP;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        RESP: begin
          wbs_ack_o <= 1'b0;
          wbs_dat_o <= '0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_user_wb_interconnect.sv
// Directed bench for user_wb_interconnect with hand-computed expected values.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_user_wb_interconnect;

  logic        clk = 1'b0;
  logic        rst;
  logic        cyc, stb, we;
  logic [3:0]  sel;
  logic [31:0] adr, wdat;
  logic        ack;
  logic [31:0] rdat;
  logic [2:0]  s_cyc, s_stb;
  logic        s_we;
  logic [3:0]  s_sel;
  logic [31:0] s_adr, s_dat;
  logic [2:0]  s_ack;
  logic [95:0] s_rdat;
  logic        err;
  logic [15:0] err_cnt;

  int n_chk = 0;
  int n_bad = 0;
  int stb_cycles;
  logic ack_seen;

  always #5 clk = ~clk;

  user_wb_interconnect #(
    .N_SLV      (3),
    .DEC_W      (12),
    .BASE_ADDRS ({12'h380, 12'h340, 12'h320}),
    .TIMEOUT    (8),
    .ERR_DATA   (32'hDEAD_BEEF)
  ) dut (
    .wb_clk_i    (clk),
    .wb_rst_i    (rst),
    .wbs_cyc_i   (cyc),
    .wbs_stb_i   (stb),
    .wbs_we_i    (we),
    .wbs_sel_i   (sel),
    .wbs_adr_i   (adr),
    .wbs_dat_i   (wdat),
    .wbs_ack_o   (ack),
    .wbs_dat_o   (rdat),
    .s_cyc_o     (s_cyc),
    .s_stb_o     (s_stb),
    .s_we_o      (s_we),
    .s_sel_o     (s_sel),
    .s_adr_o     (s_adr),
    .s_dat_o     (s_dat),
    .s_ack_i     (s_ack),
    .s_dat_i     (s_rdat),
    .err_o       (err),
    .err_count_o (err_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic master_idle();
    cyc  = 1'b0;
    stb  = 1'b0;
    we   = 1'b0;
    sel  = 4'h0;
    adr  = 32'h0;
    wdat = 32'h0;
  endtask

  task automatic master_req(input logic w, input logic [31:0] a, input logic [3:0] s,
                            input logic [31:0] d);
    cyc  = 1'b1;
    stb  = 1'b1;
    we   = w;
    adr  = a;
    sel  = s;
    wdat = d;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst    = 1'b1;
    s_ack  = '0;
    s_rdat = '0;
    master_idle();
    repeat (2) @(negedge clk);
    check("rst_ack", 32'(ack), 32'h0);
    check("rst_dat", rdat, 32'h0);
    check("rst_stb", 32'(s_stb), 32'h0);
    check("rst_cyc", 32'(s_cyc), 32'h0);
    check("rst_err", 32'(err), 32'h0);
    check("rst_cnt", 32'(err_cnt), 32'h0);
    rst = 1'b0;
    @(negedge clk);

    // Read to slave 1, ack two cycles after its strobe; address moves mid-BUSY.
    master_req(1'b0, 32'h3400_0010, 4'hF, 32'h0);
    @(negedge clk);
    check("t1_stb", 32'(s_stb), 32'h2);
    check("t1_cyc", 32'(s_cyc), 32'h2);
    check("t1_adr", s_adr, 32'h3400_0010);
    check("t1_ack_early", 32'(ack), 32'h0);
    adr = 32'h3000_0000;
    @(negedge clk);
    check("t1_adr_hold", s_adr, 32'h3400_0010);
    check("t1_stb_hold", 32'(s_stb), 32'h2);
    s_ack = 3'b010;
    s_rdat[32 +: 32] = 32'h1234_5678;
    @(negedge clk);
    check("t1_ack", 32'(ack), 32'h1);
    check("t1_rdat", rdat, 32'h1234_5678);
    check("t1_stb_drop", 32'(s_stb), 32'h0);
    check("t1_cnt", 32'(err_cnt), 32'h0);
    s_ack = '0;
    master_idle();
    @(negedge clk);
    check("t1_ack_clr", 32'(ack), 32'h0);
    check("t1_dat_clr", rdat, 32'h0);

    // Write to slave 2; slave ack is immediate and its read bus is ignored.
    master_req(1'b1, 32'h3800_0004, 4'hC, 32'hA5A5_0000);
    @(negedge clk);
    check("t2_stb", 32'(s_stb), 32'h4);
    check("t2_adr", s_adr, 32'h3800_0004);
    check("t2_dat", s_dat, 32'hA5A5_0000);
    check("t2_sel", 32'(s_sel), 32'hC);
    check("t2_we", 32'(s_we), 32'h1);
    s_ack = 3'b100;
    s_rdat[64 +: 32] = 32'hFFFF_FFFF;
    @(negedge clk);
    check("t2_ack", 32'(ack), 32'h1);
    check("t2_rdat_zero", rdat, 32'h0);
    s_ack = '0;
    master_idle();
    @(negedge clk);
    check("t2_ack_clr", 32'(ack), 32'h0);

    // Unmapped read answers on the next cycle with the error pattern.
    master_req(1'b0, 32'h3000_0000, 4'hF, 32'h0);
    @(negedge clk);
    check("t3_ack", 32'(ack), 32'h1);
    check("t3_rdat", rdat, 32'hDEAD_BEEF);
    check("t3_err", 32'(err), 32'h1);
    check("t3_cnt", 32'(err_cnt), 32'h1);
    check("t3_stb", 32'(s_stb), 32'h0);
    master_idle();
    @(negedge clk);
    check("t3_err_clr", 32'(err), 32'h0);
    check("t3_ack_clr", 32'(ack), 32'h0);

    // Slave 0 never acks: strobe held for TIMEOUT=8 cycles, then error.
    master_req(1'b0, 32'h3200_0000, 4'hF, 32'h0);
    stb_cycles = 0;
    ack_seen   = 1'b0;
    for (int i = 0; i < 20 && !ack_seen; i++) begin
      @(negedge clk);
      if (s_stb == 3'b001) stb_cycles++;
      if (ack) begin
        ack_seen = 1'b1;
        check("t4_rdat", rdat, 32'hDEAD_BEEF);
        check("t4_err", 32'(err), 32'h1);
        check("t4_stb_drop", 32'(s_stb), 32'h0);
      end
    end
    check("t4_ack_seen", 32'(ack_seen), 32'h1);
    check("t4_stb_cycles", 32'(stb_cycles), 32'd8);
    check("t4_cnt", 32'(err_cnt), 32'h2);
    master_idle();
    @(negedge clk);

    // Master abort three cycles into BUSY, then a normal access to slave 0.
    master_req(1'b0, 32'h3400_0000, 4'hF, 32'h0);
    @(negedge clk);
    check("t5_stb", 32'(s_stb), 32'h2);
    repeat (2) @(negedge clk);
    master_idle();
    @(negedge clk);
    check("t5_stb_drop", 32'(s_stb), 32'h0);
    check("t5_no_ack", 32'(ack), 32'h0);
    @(negedge clk);
    check("t5_no_ack2", 32'(ack), 32'h0);
    check("t5_cnt", 32'(err_cnt), 32'h2);
    check("t5_no_err", 32'(err), 32'h0);
    master_req(1'b0, 32'h3200_0000, 4'hF, 32'h0);
    @(negedge clk);
    check("t5b_stb", 32'(s_stb), 32'h1);
    s_ack = 3'b001;
    s_rdat[0 +: 32] = 32'hCAFE_0001;
    @(negedge clk);
    check("t5b_ack", 32'(ack), 32'h1);
    check("t5b_rdat", rdat, 32'hCAFE_0001);
    s_ack = '0;
    master_idle();
    @(negedge clk);

    // Asynchronous reset while BUSY clears everything without waiting for a clock.
    master_req(1'b0, 32'h3800_0000, 4'hF, 32'h0);
    @(negedge clk);
    check("t6_stb", 32'(s_stb), 32'h4);
    #2 rst = 1'b1;
    #1;
    check("t6_stb_rst", 32'(s_stb), 32'h0);
    check("t6_cyc_rst", 32'(s_cyc), 32'h0);
    check("t6_adr_rst", s_adr, 32'h0);
    check("t6_ack_rst", 32'(ack), 32'h0);
    check("t6_cnt_rst", 32'(err_cnt), 32'h0);
    master_idle();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("t6_no_ack", 32'(ack), 32'h0);

    // Counter saturation from a preloaded value.
    force dut.err_count_o = 16'hFFFE;
    @(negedge clk);
    release dut.err_count_o;
    check("t7_preload", 32'(err_cnt), 32'hFFFE);
    master_req(1'b0, 32'h0000_0000, 4'hF, 32'h0);
    @(negedge clk);
    check("t7_cnt_max", 32'(err_cnt), 32'hFFFF);
    master_idle();
    @(negedge clk);
    master_req(1'b0, 32'h0000_0000, 4'hF, 32'h0);
    @(negedge clk);
    check("t7_err", 32'(err), 32'h1);
    check("t7_cnt_sat", 32'(err_cnt), 32'hFFFF);
    master_idle();
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
